// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, one full-subtractor step per clock, LSB first.
// A start/busy/done handshake frames each WIDTH-cycle operation.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] partial;
    logic [WIDTH-1:0] partial_nxt;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic             d;
    logic             bn;

    // One full-subtractor cell built from two half-subtractor stages
    always_comb begin
        d           = sa[0] ^ sb[0] ^ borrow;
        bn          = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow);
        partial_nxt = {d, partial[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Result registers load only on the DONE-entry edge, so they never show partial values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa      <= '0;
            sb      <= '0;
            partial <= '0;
            cnt     <= '0;
            borrow  <= 1'b0;
            diff    <= '0;
            bout    <= 1'b0;
            zero    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa      <= a;
                        sb      <= b;
                        partial <= '0;
                        cnt     <= '0;
                        borrow  <= 1'b0;
                    end
                end
                RUN: begin
                    sa      <= {1'b0, sa[WIDTH-1:1]};
                    sb      <= {1'b0, sb[WIDTH-1:1]};
                    partial <= partial_nxt;
                    borrow  <= bn;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        diff <= partial_nxt;
                        bout <= bn;
                        zero <= (partial_nxt == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
